// File: rtl/operand_collector.sv
// Operand collector: pops register indices from the FIFO head, reads the register file,
// and packs NUM_OPS operands into one bundle handed to the MAC unit over valid/ready.
module operand_collector #(
   parameter int DATA_WIDTH = 16,
   parameter int REG_IDX_W  = 4,
   parameter int NUM_OPS    = 3,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          fifo_empty,
   input  logic [REG_IDX_W-1:0]          fifo_rd_idx,
   output logic                          fifo_read_en,
   output logic                          rf_rd_en,
   output logic [REG_IDX_W-1:0]          rf_rd_addr,
   input  logic [DATA_WIDTH-1:0]         rf_rd_data,
   output logic                          op_valid,
   input  logic                          op_ready,
   output logic [NUM_OPS*DATA_WIDTH-1:0] op_bundle,
   output logic                          busy,
   output logic [CNT_W-1:0]              bundles_issued
);

   localparam int CW = $clog2(NUM_OPS + 1);

   typedef enum logic [1:0] {COLLECT, DRAIN, ISSUE} state_t;

   state_t                state;
   logic [CW-1:0]         pop_cnt;
   logic [CW-1:0]         cap_cnt;
   logic                  rd_pending;
   logic [DATA_WIDTH-1:0] slot [NUM_OPS];
   logic                  pop;

   // Pop is gated by reset so nothing leaves the FIFO while the block is being cleared.
   assign pop          = !reset && (state == COLLECT) && !fifo_empty;
   assign fifo_read_en = pop;
   assign rf_rd_en     = pop;
   assign rf_rd_addr   = pop ? fifo_rd_idx : '0;
   assign busy         = (pop_cnt != '0) | op_valid;

   for (genvar k = 0; k < NUM_OPS; k++) begin : g_pack
      assign op_bundle[k*DATA_WIDTH +: DATA_WIDTH] = slot[k];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= COLLECT;
         pop_cnt        <= '0;
         cap_cnt        <= '0;
         rd_pending     <= 1'b0;
         op_valid       <= 1'b0;
         bundles_issued <= '0;
         for (int k = 0; k < NUM_OPS; k++) slot[k] <= '0;
      end else begin
         rd_pending <= pop;
         // Read data lands one cycle after its pop, so capture order follows pop order.
         if (rd_pending) begin
            for (int k = 0; k < NUM_OPS; k++)
               if (cap_cnt == CW'(k)) slot[k] <= rf_rd_data;
            cap_cnt <= cap_cnt + 1'b1;
         end
         case (state)
            COLLECT: begin
               if (pop) begin
                  pop_cnt <= pop_cnt + 1'b1;
                  if (pop_cnt == CW'(NUM_OPS - 1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               state    <= ISSUE;
               op_valid <= 1'b1;
            end
            ISSUE: begin
               if (op_ready) begin
                  bundles_issued <= bundles_issued + 1'b1;
                  pop_cnt        <= '0;
                  cap_cnt        <= '0;
                  op_valid       <= 1'b0;
                  state          <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: FIFO and register-file models, fixed-timing scenarios
// and a randomized run scored against a queue of pushed indices.
module tb_operand_collector;

   localparam int DW = 16;
   localparam int IW = 4;
   localparam int N  = 3;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            fifo_empty;
   logic [IW-1:0]   fifo_rd_idx;
   logic            fifo_read_en;
   logic            rf_rd_en;
   logic [IW-1:0]   rf_rd_addr;
   logic [DW-1:0]   rf_rd_data;
   logic            op_valid;
   logic            op_ready = 1'b0;
   logic [N*DW-1:0] op_bundle;
   logic            busy;
   logic [CW-1:0]   bundles_issued;

   int checks = 0;
   int errors = 0;

   logic [IW-1:0] fifo_mem [256];
   logic [7:0]    head = '0;
   logic [7:0]    tail = '0;
   logic [DW-1:0] rf_mem [16];
   logic [IW-1:0] q [$];

   operand_collector #(.DATA_WIDTH(DW), .REG_IDX_W(IW), .NUM_OPS(N), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_idx(fifo_rd_idx),
      .fifo_read_en(fifo_read_en), .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr),
      .rf_rd_data(rf_rd_data), .op_valid(op_valid), .op_ready(op_ready),
      .op_bundle(op_bundle), .busy(busy), .bundles_issued(bundles_issued)
   );

   always #5 clk = ~clk;

   assign fifo_empty  = (head == tail);
   assign fifo_rd_idx = fifo_mem[head];

   always @(posedge clk) begin
      if (fifo_read_en) head <= head + 8'd1;
      if (rf_rd_en) rf_rd_data <= rf_mem[rf_rd_addr];
   end

   task automatic push(input logic [IW-1:0] idx);
      fifo_mem[tail] = idx;
      tail = tail + 8'd1;
      q.push_back(idx);
   endtask

   // Reference: a bundle is the RF contents of the next N indices in push order, first in LSBs.
   task automatic pop_expected(output logic [N*DW-1:0] b);
      b = 'x;
      if (q.size() >= N)
         for (int k = 0; k < N; k++) b[k*DW +: DW] = rf_mem[q.pop_front()];
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      op_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({fifo_read_en, rf_rd_en, op_valid, busy} !== 4'b0) begin
         errors++; $display("FAIL reset_ctrl got %b required 0000", {fifo_read_en, rf_rd_en, op_valid, busy});
      end
      checks++;
      if (rf_rd_addr !== '0) begin errors++; $display("FAIL reset_addr got %h required 0", rf_rd_addr); end
      checks++;
      if (op_bundle !== '0) begin errors++; $display("FAIL reset_bundle got %h required 0", op_bundle); end
      checks++;
      if (bundles_issued !== '0) begin errors++; $display("FAIL reset_count got %0d required 0", bundles_issued); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      op_ready = 1'b1;
      push(4'd1); push(4'd2); push(4'd3);
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++;
         if (fifo_read_en !== (c < 3)) begin errors++; $display("FAIL basic_pop c=%0d got %b required %b", c, fifo_read_en, c < 3); end
         checks++;
         if (op_valid !== (c == 4)) begin errors++; $display("FAIL basic_valid c=%0d got %b required %b", c, op_valid, c == 4); end
         if (c < 3) begin
            checks++;
            if (rf_rd_addr !== IW'(c + 1)) begin errors++; $display("FAIL basic_addr c=%0d got %h required %h", c, rf_rd_addr, c + 1); end
         end
         if (c == 4) begin
            checks++;
            if (op_bundle !== {16'h0303, 16'h0202, 16'h0101}) begin
               errors++; $display("FAIL basic_bundle got %h required 030302020101", op_bundle);
            end
         end
         if (c == 5) begin
            checks++;
            if (bundles_issued !== 16'd1) begin errors++; $display("FAIL basic_count got %0d required 1", bundles_issued); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      op_ready = 1'b0;
      push(4'd1); push(4'd2); push(4'd3); push(4'd4);
      for (int c = 0; c < 11; c++) begin
         op_ready = (c >= 9);
         #1;
         checks++;
         if (fifo_read_en !== (c < 3 || c == 10)) begin errors++; $display("FAIL bp_pop c=%0d got %b", c, fifo_read_en); end
         checks++;
         if (op_valid !== (c >= 4 && c <= 9)) begin errors++; $display("FAIL bp_valid c=%0d got %b", c, op_valid); end
         if (c >= 4 && c <= 9) begin
            checks++;
            if (op_bundle !== {16'h0303, 16'h0202, 16'h0101}) begin
               errors++; $display("FAIL bp_hold c=%0d got %h required 030302020101", c, op_bundle);
            end
         end
         if (c == 10) begin
            checks++;
            if (rf_rd_addr !== 4'd4) begin errors++; $display("FAIL bp_resume_addr got %h required 4", rf_rd_addr); end
            checks++;
            if (bundles_issued !== 16'd2) begin errors++; $display("FAIL bp_count got %0d required 2", bundles_issued); end
         end
         @(negedge clk);
      end
      apply_reset();
   endtask

   task automatic test_stall();
      op_ready = 1'b1;
      push(4'd5); push(4'd6);
      for (int c = 0; c < 10; c++) begin
         if (c == 6) push(4'd7);
         #1;
         checks++;
         if (fifo_read_en !== (c < 2 || c == 6)) begin errors++; $display("FAIL stall_pop c=%0d got %b", c, fifo_read_en); end
         checks++;
         if (op_valid !== (c == 8)) begin errors++; $display("FAIL stall_valid c=%0d got %b", c, op_valid); end
         if (c >= 2 && c < 6) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy c=%0d got %b required 1", c, busy); end
         end
         if (c == 8) begin
            checks++;
            if (op_bundle !== {rf_mem[7], rf_mem[6], rf_mem[5]}) begin
               errors++; $display("FAIL stall_bundle got %h required %h", op_bundle, {rf_mem[7], rf_mem[6], rf_mem[5]});
            end
         end
         if (c == 9) begin
            checks++;
            if (bundles_issued !== 16'd1) begin errors++; $display("FAIL stall_count got %0d required 1", bundles_issued); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      op_ready = 1'b1;
      push(4'd1); push(4'd2);
      for (int c = 0; c < 9; c++) begin
         if (c == 2) reset = 1'b1;
         if (c == 3) begin reset = 1'b0; push(4'd8); push(4'd9); push(4'd10); end
         #1;
         checks++;
         if (fifo_read_en !== (c < 2 || (c >= 3 && c <= 5))) begin errors++; $display("FAIL rmid_pop c=%0d got %b", c, fifo_read_en); end
         if (c == 3) begin
            checks++;
            if ({op_valid, busy} !== 2'b00) begin errors++; $display("FAIL rmid_clear got %b required 00", {op_valid, busy}); end
            checks++;
            if (bundles_issued !== '0) begin errors++; $display("FAIL rmid_count got %0d required 0", bundles_issued); end
         end
         checks++;
         if (op_valid !== (c == 7)) begin errors++; $display("FAIL rmid_valid c=%0d got %b", c, op_valid); end
         if (c == 7) begin
            checks++;
            if (op_bundle !== {rf_mem[10], rf_mem[9], rf_mem[8]}) begin
               errors++; $display("FAIL rmid_bundle got %h required %h", op_bundle, {rf_mem[10], rf_mem[9], rf_mem[8]});
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [N*DW-1:0] exp;
      int hs = 0;
      int hs_cyc [2];
      apply_reset();
      for (int r = 0; r < 16; r++) rf_mem[r] = DW'($urandom);
      op_ready = 1'b1;
      for (int i = 0; i < 6; i++) push(IW'($urandom_range(0, 15)));
      for (int c = 0; c < 40 && hs < 2; c++) begin
         #1;
         if (op_valid && op_ready) begin
            pop_expected(exp);
            checks++;
            if (op_bundle !== exp) begin errors++; $display("FAIL b2b_bundle%0d got %h required %h", hs, op_bundle, exp); end
            hs_cyc[hs] = c;
            hs++;
         end
         @(negedge clk);
      end
      checks++;
      if (hs != 2) begin
         errors++; $display("FAIL b2b_timeout got %0d handshakes required 2", hs);
      end else begin
         checks++;
         if (hs_cyc[0] != 4) begin errors++; $display("FAIL b2b_first got cycle %0d required 4", hs_cyc[0]); end
         checks++;
         if (hs_cyc[1] - hs_cyc[0] != 5) begin errors++; $display("FAIL b2b_period got %0d required 5", hs_cyc[1] - hs_cyc[0]); end
      end
      #1;
      checks++;
      if (bundles_issued !== 16'd2) begin errors++; $display("FAIL b2b_count got %0d required 2", bundles_issued); end
   endtask

   task automatic test_wrap();
      logic [N*DW-1:0] exp;
      int hs = 0;
      q.delete();
      force dut.bundles_issued = 16'hFFFF;
      #1;
      release dut.bundles_issued;
      op_ready = 1'b1;
      for (int i = 0; i < 3; i++) push(IW'($urandom_range(0, 15)));
      for (int c = 0; c < 20 && hs == 0; c++) begin
         #1;
         if (op_valid && op_ready) begin
            pop_expected(exp);
            checks++;
            if (op_bundle !== exp) begin errors++; $display("FAIL wrap_bundle got %h required %h", op_bundle, exp); end
            hs++;
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (hs != 1 || bundles_issued !== 16'd0) begin
         errors++; $display("FAIL wrap_count got %0d (handshakes %0d) required 0", bundles_issued, hs);
      end
   endtask

   task automatic test_random();
      logic [N*DW-1:0] exp;
      logic [N*DW-1:0] held;
      logic            hold = 1'b0;
      int pushed = 0;
      int hs = 0;
      apply_reset();
      for (int r = 0; r < 16; r++) rf_mem[r] = DW'($urandom);
      for (int c = 0; c < 1500 && !(pushed == 30 && hs == 10); c++) begin
         if (pushed < 30 && $urandom_range(0, 2) != 0) begin
            push(IW'($urandom_range(0, 15)));
            pushed++;
         end
         op_ready = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (rf_rd_en !== fifo_read_en || (fifo_read_en && fifo_empty)) begin
            errors++; $display("FAIL rnd_strobe c=%0d rd_en %b read_en %b empty %b", c, rf_rd_en, fifo_read_en, fifo_empty);
         end
         if (hold) begin
            checks++;
            if (op_valid !== 1'b1 || op_bundle !== held) begin
               errors++; $display("FAIL rnd_hold c=%0d got %b/%h required 1/%h", c, op_valid, op_bundle, held);
            end
         end
         if (op_valid && op_ready) begin
            pop_expected(exp);
            checks++;
            if (op_bundle !== exp) begin errors++; $display("FAIL rnd_bundle%0d got %h required %h", hs, op_bundle, exp); end
            hs++;
         end
         hold = op_valid && !op_ready;
         held = op_bundle;
         @(negedge clk);
      end
      #1;
      checks++;
      if (hs != 10 || bundles_issued !== 16'd10) begin
         errors++; $display("FAIL rnd_count got %0d (handshakes %0d) required 10", bundles_issued, hs);
      end
   endtask

   initial begin
      for (int r = 0; r < 16; r++) rf_mem[r] = DW'(r * 16'h0101);
      test_reset();
      test_basic();
      test_backpressure();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
